// File: rtl/taillight_pkg.sv
// Shared types and defaults for the tail-light sequencer.
package taillight_pkg;

  localparam int LAMPS_DEF = 3;
  localparam int DIV_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEFT,
    RIGHT,
    BRAKE,
    HAZARD
  } mode_e;

  // Sequencer state; phase is wide enough for up to 8 lamps per side.
  typedef struct packed {
    mode_e      mode;
    logic [3:0] phase;
  } seq_state_t;

  // Hazard outranks a single turn side, which outranks brake.
  function automatic mode_e select_mode(input logic hz, input logic lt,
                                        input logic rt, input logic brk);
    mode_e m;
    m = IDLE;
    if (hz)       m = HAZARD;
    else if (lt)  m = LEFT;
    else if (rt)  m = RIGHT;
    else if (brk) m = BRAKE;
    return m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: step is high for one clock out of every DIV.
module tick_gen
  import taillight_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic Reset,
  output logic step
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign step = (cnt_q == LAST);

endmodule

// File: rtl/taillight_seq.sv
// Tail-light sequencer: turn, hazard and brake patterns advanced once per step.
// Optional build macro TAILLIGHT_BRAKE_EN enables the brake input.
module taillight_seq
  import taillight_pkg::*;
#(
  parameter int LAMPS = LAMPS_DEF,
  parameter int DIV   = DIV_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] L,
  output logic [LAMPS-1:0] R,
  output logic             step
);

  localparam logic [3:0] LAST_PH = 4'(LAMPS);

  logic brk;
`ifdef TAILLIGHT_BRAKE_EN
  assign brk = brake;
`else
  logic brake_unused;
  assign brake_unused = brake;
  assign brk          = 1'b0;
`endif

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .Reset(Reset),
    .step (step)
  );

  seq_state_t       state_q, state_d;
  mode_e            sel_mode;
  logic             restart;
  logic [LAMPS-1:0] L_q, L_d, R_q, R_d, thermo;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= '{mode: IDLE, phase: '0};
      L_q     <= '0;
      R_q     <= '0;
    end else if (step) begin
      state_q <= state_d;
      L_q     <= L_d;
      R_q     <= R_d;
    end
  end

  // Brake is not part of the mode while turning, so toggling it never restarts the sweep.
  always_comb begin
    sel_mode      = select_mode(hazard | (left & right), left, right, brk);
    restart       = (sel_mode != state_q.mode);
    state_d.mode  = sel_mode;
    state_d.phase = '0;
    case (sel_mode)
      LEFT, RIGHT: begin
        if (restart)                        state_d.phase = 4'd1;
        else if (state_q.phase == LAST_PH)  state_d.phase = '0;
        else                                state_d.phase = state_q.phase + 4'd1;
      end
      HAZARD:  state_d.phase = (restart || state_q.phase == 4'd0) ? 4'd1 : 4'd0;
      default: state_d.phase = '0;
    endcase
  end

  always_comb begin
    thermo = '0;
    for (int i = 0; i < LAMPS; i++) thermo[i] = (i < int'(state_d.phase));
    L_d = '0;
    R_d = '0;
    case (state_d.mode)
      LEFT: begin
        L_d = thermo;
        R_d = brk ? '1 : '0;
      end
      RIGHT: begin
        R_d = thermo;
        L_d = brk ? '1 : '0;
      end
      BRAKE: begin
        L_d = '1;
        R_d = '1;
      end
      HAZARD: begin
        L_d = state_d.phase[0] ? '1 : '0;
        R_d = state_d.phase[0] ? '1 : '0;
      end
      default: begin
        L_d = '0;
        R_d = '0;
      end
    endcase
  end

  assign L = L_q;
  assign R = R_q;

endmodule

// File: tb/tb_taillight_seq.sv
// Bench for taillight_seq (LAMPS=3, DIV=4) against an arithmetic reference model.
module tb_taillight_seq;

  localparam int         LAMPS = 3;
  localparam int         DIV   = 4;
  localparam logic [2:0] ALL   = 3'b111;
`ifdef TAILLIGHT_BRAKE_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic Reset, left, right, hazard, brake;
  logic [LAMPS-1:0] L, R;
  logic step;

  always #5 clk = ~clk;

  taillight_seq #(.LAMPS(LAMPS), .DIV(DIV)) dut (
    .clk   (clk),
    .Reset (Reset),
    .left  (left),
    .right (right),
    .hazard(hazard),
    .brake (brake),
    .L     (L),
    .R     (R),
    .step  (step)
  );

  // reference model: 0 idle, 1 left, 2 right, 3 brake, 4 hazard
  int         m_mode, m_ph, m_cnt;
  logic [2:0] el, er;
  logic [6:0] exp_q[$];
  int         n_cmp, n_bad;
  logic [2:0] step_l_q[$];

  task automatic model_edge();
    int  nm;
    bit  b, hz, rs;
    logic [2:0] side, oth;
    if (Reset) begin
      m_cnt = 0; m_mode = 0; m_ph = 0; el = '0; er = '0;
    end else begin
      if (m_cnt == DIV - 1) begin
        b  = BRK_EN && brake;
        hz = hazard || (left && right);
        nm = hz ? 4 : left ? 1 : right ? 2 : b ? 3 : 0;
        rs = (nm != m_mode);
        m_mode = nm;
        case (nm)
          1, 2: begin
            m_ph = rs ? 1 : (m_ph + 1) % (LAMPS + 1);
            side = 3'((1 << m_ph) - 1);
            oth  = b ? ALL : 3'b000;
            if (nm == 1) begin el = side; er = oth;  end
            else         begin el = oth;  er = side; end
          end
          3: begin m_ph = 0; el = ALL; er = ALL; end
          4: begin
            m_ph = rs ? 1 : 1 - m_ph;
            el = (m_ph == 1) ? ALL : 3'b000;
            er = el;
          end
          default: begin m_ph = 0; el = '0; er = '0; end
        endcase
      end
      m_cnt = (m_cnt + 1) % DIV;
    end
    exp_q.push_back({(m_cnt == DIV - 1), el, er});
  endtask

  // scoreboard check
  task automatic check();
    logic [6:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    assert (step === e[6]) else begin
      n_bad++;
      $error("FAIL step t=%0t got %b exp %b", $time, step, e[6]);
    end
    n_cmp++;
    assert (L === e[5:3]) else begin
      n_bad++;
      $error("FAIL L t=%0t got %b exp %b", $time, L, e[5:3]);
    end
    n_cmp++;
    assert (R === e[2:0]) else begin
      n_bad++;
      $error("FAIL R t=%0t got %b exp %b", $time, R, e[2:0]);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic l, input logic r, input logic h, input logic b);
    left = l; right = r; hazard = h; brake = b;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check();
    end
  endtask

  task automatic run_log(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check();
      if (step_l_q.size() < 8 && m_cnt == 0) step_l_q.push_back(L);
    end
  endtask

  initial begin
    logic [2:0] want[5];
    n_cmp = 0; n_bad = 0;
    m_mode = 0; m_ph = 0; m_cnt = 0; el = '0; er = '0;
    Reset = 1'b1;
    set_in(0, 0, 0, 0);
    run(3);
    Reset = 1'b0;

    // left held: 001,011,111,000,001 on successive steps
    set_in(1, 0, 0, 0);
    run_log(20);
    want = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      assert (step_l_q[i] === want[i]) else begin
        n_bad++;
        $error("FAIL left_seq[%0d] got %b exp %b", i, step_l_q[i], want[i]);
      end
    end

    // right with brake
    set_in(0, 1, 0, 1);
    run(20);
    // both sides, then hazard
    set_in(1, 1, 0, 0);
    run(12);
    set_in(0, 0, 1, 0);
    run(12);
    set_in(0, 0, 0, 0);
    run(6);

    // reset pulse mid-sequence
    Reset = 1'b1;
    run(1);
    Reset = 1'b0;
    set_in(1, 0, 0, 0);
    run(8);
    Reset = 1'b1;
    run(1);
    Reset = 1'b0;
    run(10);

    // side switch between steps
    set_in(0, 1, 0, 0);
    run(9);

    // brake alone, then brake with left, brake toggled while turning
    set_in(0, 0, 0, 1);
    run(12);
    set_in(1, 0, 0, 1);
    run(10);
    set_in(1, 0, 0, 0);
    run(6);
    set_in(1, 0, 0, 1);
    run(6);

    // short glitch that reverts before the next step
    set_in(1, 0, 0, 0);
    run(1);
    set_in(0, 1, 0, 0);
    run(1);
    set_in(1, 0, 0, 0);
    run(8);

    // randomized phase
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        int v;
        v = $urandom_range(0, 15);
        if ($urandom_range(0, 2) != 0) v = v & ~4;
        set_in(v[0], v[1], v[2], v[3]);
      end
      Reset = ($urandom_range(0, 59) == 0);
      run(1);
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
